dm_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single data-memory/Bridge port between the CPU M-stage data port (master 0) and a DMA/debug master (master 1). It sits between the CPU, the second master and the Bridge. It grants at most one transaction per cycle, forwards the winner's address, write data and byte enables to the slave side, and routes read data back to the issuing master after a fixed slave latency.

---
 rtl/dm_bus_arbiter_pkg.sv | 16 +
 rtl/dm_bus_arbiter_if.sv | 24 ++
 rtl/arb_rd_tag_pipe.sv | 35 +++
 rtl/dm_bus_arbiter.sv | 115 +++++++++++
 tb/tb_dm_bus_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared types for the data-memory bus arbiter.
// Master ids and the read-tag bundle carried down the tag pipe.
package dm_arb_pkg;

  typedef logic mst_id_t;

  typedef struct packed {
    logic    valid;
    mst_id_t id;
  } arb_tag_t;

  localparam mst_id_t MST_CPU = 1'b0;
  localparam mst_id_t MST_DMA = 1'b1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// Per-master request/response bundle of the data-memory bus.
// The arbiter takes the slave view, each requester the master view.
interface dm_bus_arbiter_if;
  import dm_arb_pkg::*;

  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, wdata, byteen,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, wdata, byteen,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/arb_rd_tag_pipe.sv
// Delay line of read tags matching the slave read latency.
// Depth 0 degenerates to a combinational pass-through.
module arb_rd_tag_pipe
  import dm_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  arb_tag_t d,
  output arb_tag_t q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ reset;
    assign q = d;
  end else begin : g_pipe
    arb_tag_t sr [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++)
          sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter in front of the data-memory/Bridge port.
// Zero-latency grant, fixed-latency in-order read return.
module dm_bus_arbiter
  import dm_arb_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int CPU_PRIO   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  dm_bus_arbiter_if.slave   m0,
  dm_bus_arbiter_if.slave   m1,
  output logic [31:0]       s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_byteen,
  output logic              s_rd,
  input  logic [31:0]       s_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  mst_id_t    last_q;
  mst_id_t    win;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       any_gnt;
  logic       gnt0;
  logic       gnt1;
  logic       rv0;
  logic       rv1;
  arb_tag_t   tag_in;
  arb_tag_t   tag_out;

  always_comb begin
    win = MST_CPU;
    if (m0.req && m1.req) begin
      if (CPU_PRIO != 0)
        win = (starve_q == SMAX) ? MST_DMA : MST_CPU;
      else
        win = ~last_q;
    end else if (m1.req) begin
      win = MST_DMA;
    end
  end

  assign any_gnt = !reset && (m0.req || m1.req);
  assign gnt0    = any_gnt && (win == MST_CPU);
  assign gnt1    = any_gnt && (win == MST_DMA);
  assign m0.gnt  = gnt0;
  assign m1.gnt  = gnt1;

  always_comb begin
    s_addr   = '0;
    s_wdata  = '0;
    s_byteen = '0;
    unique case (1'b1)
      gnt0: begin
        s_addr   = m0.addr;
        s_wdata  = m0.wdata;
        s_byteen = m0.byteen;
      end
      gnt1: begin
        s_addr   = m1.addr;
        s_wdata  = m1.wdata;
        s_byteen = m1.byteen;
      end
      default: ;
    endcase
    s_rd = any_gnt && (s_byteen == 4'd0);
  end

  // Guard counts only while master 1 keeps waiting.
  always_comb begin
    starve_d = starve_q;
    if (gnt1 || !m1.req)
      starve_d = '0;
    else if (gnt0 && starve_q != SMAX)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= MST_DMA;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (any_gnt)
        last_q <= win;
    end
  end

  assign tag_in.valid = s_rd;
  assign tag_in.id    = win;

  arb_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (tag_in),
    .q     (tag_out)
  );

  assign rv0 = !reset && tag_out.valid
             && (tag_out.id == MST_CPU);
  assign rv1 = !reset && tag_out.valid
             && (tag_out.id == MST_DMA);

  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.rdata  = rv0 ? s_rdata : '0;
  assign m1.rdata  = rv1 ? s_rdata : '0;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Three arbiter configurations driven by one stimulus stream,
// each compared cycle by cycle with a behavioural model.
module tb_dm_bus_arbiter;

  localparam int NI   = 3;
  localparam int MAXC = 1024;
  localparam int LAT  [NI] = '{2, 0, 3};
  localparam int PRIO [NI] = '{0, 1, 1};
  localparam int SMAX [NI] = '{4, 4, 2};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] addr0 = '0;
  logic [31:0] addr1 = '0;
  logic [31:0] wd0 = '0;
  logic [31:0] wd1 = '0;
  logic [3:0]  be0 = '0;
  logic [3:0]  be1 = '0;
  logic [31:0] sr = '0;

  logic        o_g0  [NI];
  logic        o_g1  [NI];
  logic        o_rv0 [NI];
  logic        o_rv1 [NI];
  logic [31:0] o_rd0 [NI];
  logic [31:0] o_rd1 [NI];
  logic [31:0] o_sa  [NI];
  logic [31:0] o_sw  [NI];
  logic [3:0]  o_sb  [NI];
  logic        o_srd [NI];

  dm_bus_arbiter_if mi0 [NI] ();
  dm_bus_arbiter_if mi1 [NI] ();

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign mi0[g].req    = req0;
    assign mi0[g].addr   = addr0;
    assign mi0[g].wdata  = wd0;
    assign mi0[g].byteen = be0;
    assign mi1[g].req    = req1;
    assign mi1[g].addr   = addr1;
    assign mi1[g].wdata  = wd1;
    assign mi1[g].byteen = be1;
    assign o_g0[g]  = mi0[g].gnt;
    assign o_g1[g]  = mi1[g].gnt;
    assign o_rv0[g] = mi0[g].rvalid;
    assign o_rv1[g] = mi1[g].rvalid;
    assign o_rd0[g] = mi0[g].rdata;
    assign o_rd1[g] = mi1[g].rdata;

    dm_bus_arbiter #(
      .RD_LAT     (LAT[g]),
      .CPU_PRIO   (PRIO[g]),
      .STARVE_MAX (SMAX[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .m0       (mi0[g]),
      .m1       (mi1[g]),
      .s_addr   (o_sa[g]),
      .s_wdata  (o_sw[g]),
      .s_byteen (o_sb[g]),
      .s_rd     (o_srd[g]),
      .s_rdata  (sr)
    );
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rst = -1;
  int last_g [NI] = '{1, 1, 1};
  int starve [NI] = '{0, 0, 0};
  bit hv  [NI][MAXC];
  bit hid [NI][MAXC];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst,
                      input bit r0, input bit r1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] w0, input logic [31:0] w1,
                      input logic [3:0] b0, input logic [3:0] b1,
                      input logic [31:0] rd);
    @(posedge clk);
    #1;
    reset = rst;
    req0 = r0; req1 = r1;
    addr0 = a0; addr1 = a1;
    wd0 = w0; wd1 = w1;
    be0 = b0; be1 = b1;
    sr = rd;
    if (rst) last_rst = cyc;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      int w;
      int src;
      bit any, eg0, eg1, erd, ev, eid;
      logic [31:0] ea, ew;
      logic [3:0] eb;
      any = !rst && (r0 || r1);
      if (r0 && r1)
        w = (PRIO[k] != 0) ? int'(starve[k] == SMAX[k])
                           : 1 - last_g[k];
      else
        w = r1 ? 1 : 0;
      eg0 = any && w == 0;
      eg1 = any && w == 1;
      ea = eg0 ? a0 : eg1 ? a1 : 32'd0;
      ew = eg0 ? w0 : eg1 ? w1 : 32'd0;
      eb = eg0 ? b0 : eg1 ? b1 : 4'd0;
      erd = any && eb == 4'd0;
      hv[k][cyc]  = erd;
      hid[k][cyc] = (w == 1);
      src = cyc - LAT[k];
      ev  = 1'b0;
      eid = 1'b0;
      if (src >= 0 && src > last_rst) begin
        ev  = hv[k][src];
        eid = hid[k][src];
      end
      chk($sformatf("i%0d c%0d gnt/rd/rv", k, cyc),
          {27'd0, o_g0[k], o_g1[k], o_srd[k],
           o_rv0[k], o_rv1[k]},
          {27'd0, eg0, eg1, erd, ev && !eid, ev && eid});
      chk($sformatf("i%0d c%0d s_addr", k, cyc),
          o_sa[k], ea);
      chk($sformatf("i%0d c%0d s_wdata", k, cyc),
          o_sw[k], ew);
      chk($sformatf("i%0d c%0d s_byteen", k, cyc),
          {28'd0, o_sb[k]}, {28'd0, eb});
      chk($sformatf("i%0d c%0d m0_rdata", k, cyc),
          o_rd0[k], (ev && !eid) ? rd : 32'd0);
      chk($sformatf("i%0d c%0d m1_rdata", k, cyc),
          o_rd1[k], (ev && eid) ? rd : 32'd0);
      if (rst) begin
        last_g[k] = 1;
        starve[k] = 0;
      end else begin
        if (any) last_g[k] = w;
        if (eg1 || !r1)
          starve[k] = 0;
        else if (eg0 && starve[k] < SMAX[k])
          starve[k] = starve[k] + 1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input logic [31:0] rd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, rd);
  endtask

  initial begin
    logic [3:0] pat_rr;
    logic [9:0] pat_sv;
    logic       any_rv;
    pat_rr = '0;
    pat_sv = '0;

    repeat (3)
      step(1, 1, 1, 32'h1000, 32'h2000, 1, 2, 4'hf, 4'hf, 0);

    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 32'h1000, 32'h2000,
           32'h11, 32'h22, 4'hf, 4'hf, 0);
      pat_rr = {pat_rr[2:0], o_g1[0]};
    end
    chk("rr grant order", {28'd0, pat_rr}, 32'h5);

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 32'h1000 + i, 32'h2000 + i,
           i, ~i, 4'h1, 4'h8, 0);
      pat_sv = {pat_sv[8:0], o_g1[1]};
    end
    chk("starve grant pattern", {22'd0, pat_sv}, 32'h21);

    idle(0);
    step(0, 1, 0, 32'h10, 0, 0, 0, 4'h0, 4'h0, 0);
    step(0, 0, 1, 0, 32'h14, 0, 0, 4'h0, 4'h0, 0);
    idle(32'hAAAA_0001);
    chk("route m0 rdata", o_rd0[0], 32'hAAAA_0001);
    idle(32'hBBBB_0002);
    chk("route m1 rdata", o_rd1[0], 32'hBBBB_0002);
    idle(32'hCCCC_0003);

    step(0, 1, 0, 32'h40, 0, 0, 0, 4'h0, 4'h0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    any_rv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(32'hDEAD_0000 + i);
      any_rv = any_rv | o_rv0[2] | o_rv1[2];
    end
    chk("rvalid after reset", {31'd0, any_rv}, 32'd0);

    step(0, 0, 1, 0, 32'h80, 0, 32'h5555, 4'h0, 4'h3, 0);
    chk("lat0 write byteen", {28'd0, o_sb[1]}, 32'h3);
    step(0, 0, 1, 0, 32'h84, 0, 0, 4'h0, 4'h0, 32'h1234_5678);
    chk("lat0 read rvalid", {31'd0, o_rv1[1]}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      bit rs;
      rs = ($urandom_range(39) == 0);
      step(rs, 1'($urandom), 1'($urandom),
           $urandom, $urandom, $urandom, $urandom,
           ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0,
           ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0,
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
